// File: rtl/operand_entry_bank_pkg.sv
// Shared calculator definitions: FSM encodings, default debounce length and
// the width helper used to size operand indices and counters.
package operand_entry_bank_pkg;

  typedef enum logic [0:0] {
    ST_ENTRY = 1'b0,
    ST_FULL  = 1'b1
  } bank_state_e;

  // 1 ms at 50 MHz
  localparam int DEBOUNCE_CYC_DEFAULT = 50000;

  // ceil(log2(value)), never less than 1 so single-entry fields still get a bit
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/operand_entry_bank_btn_conditioner.sv
// Conditions one raw active-low pushbutton: 2-flop synchroniser, stability
// debounce, and a one-cycle press pulse on the accepted 1->0 transition.
// Until a genuine released level has been seen after reset, presses are not
// reported, so a button held through reset needs a release and a new press.
module btn_conditioner
  import operand_entry_bank_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fill_q, fill_d;
  logic             armed_q, armed_d;
  logic             pulse_q, pulse_d;

  // Next-state: synchronise, count disagreement, accept after a stable run
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // fill_q[1] marks that sync2_q now carries a real sample, not the reset value
    armed_d = armed_q | (fill_q[1] & sync2_q & level_q);
    pulse_d = armed_q & level_q & ~level_d;
  end

  // State registers; everything resets to the released level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/operand_entry_bank.sv
// Operand entry bank: captures NUM_OPS switch operands in order on LOAD
// presses, tracks which are valid, and is emptied by CLEAR or by the consumer.
//
// Consume handshake: consume is a one-cycle pulse from the consumer. It is
// honoured only while all_valid is high (FULL); it drops all valid flags and
// rewinds cur_idx, but keeps operand data. In ENTRY it is ignored. Same-cycle
// priority is clear > consume > load; a load coinciding with a consume in FULL
// is discarded.
module operand_entry_bank
  import operand_entry_bank_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NUM_OPS      = 2,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int IDX_W        = clog2_min1(NUM_OPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         sw,
  input  logic                      load_btn,
  input  logic                      clr_btn,
  input  logic                      consume,
  output logic [NUM_OPS*DATA_W-1:0] ops_flat,
  output logic [NUM_OPS-1:0]        op_valid,
  output logic [IDX_W-1:0]          cur_idx,
  output logic                      all_valid
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPS - 1);

  logic load_pulse;
  logic clr_pulse;

  bank_state_e         state_q, state_d;
  logic [DATA_W-1:0]   ops_q [NUM_OPS];
  logic [DATA_W-1:0]   ops_d [NUM_OPS];
  logic [NUM_OPS-1:0]  valid_q, valid_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_load_btn (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (load_btn),
    .press_pulse (load_pulse)
  );

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr_btn (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (clr_btn),
    .press_pulse (clr_pulse)
  );

  // Next-state and operand updates: clear wins, then the per-state action
  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (clr_pulse) begin
      for (int i = 0; i < NUM_OPS; i++) ops_d[i] = '0;
      valid_d = '0;
      idx_d   = '0;
      state_d = ST_ENTRY;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (load_pulse) begin
            for (int i = 0; i < NUM_OPS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                ops_d[i]   = sw;
                valid_d[i] = 1'b1;
              end
            end
            if (idx_q == IDX_LAST) state_d = ST_FULL;
            else                   idx_d   = idx_q + IDX_W'(1);
          end
        end
        ST_FULL: begin
          if (consume) begin
            valid_d = '0;
            idx_d   = '0;
            state_d = ST_ENTRY;
          end
        end
        default: state_d = ST_ENTRY;
      endcase
    end
  end

  // Bank registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ENTRY;
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= ops_d[i];
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_flat
    assign ops_flat[g*DATA_W +: DATA_W] = ops_q[g];
  end

  assign op_valid  = valid_q;
  assign cur_idx   = idx_q;
  assign all_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_operand_entry_bank.sv
// Bench for operand_entry_bank: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural model.
module tb_operand_entry_bank;

  localparam int DATA_W  = 8;
  localparam int NUM_OPS = 2;
  localparam int DEB     = 4;
  localparam int IDX_W   = 1;

  // ---------------- clock / reset / DUT ----------------
  logic                      clk = 1'b0;
  logic                      rst;
  logic [DATA_W-1:0]         sw;
  logic                      load_btn;
  logic                      clr_btn;
  logic                      consume;
  logic [NUM_OPS*DATA_W-1:0] ops_flat;
  logic [NUM_OPS-1:0]        op_valid;
  logic [IDX_W-1:0]          cur_idx;
  logic                      all_valid;

  always #5 clk = ~clk;

  operand_entry_bank #(
    .DATA_W       (DATA_W),
    .NUM_OPS      (NUM_OPS),
    .DEBOUNCE_CYC (DEB),
    .IDX_W        (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .load_btn  (load_btn),
    .clr_btn   (clr_btn),
    .consume   (consume),
    .ops_flat  (ops_flat),
    .op_valid  (op_valid),
    .cur_idx   (cur_idx),
    .all_valid (all_valid)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per button (0 = load, 1 = clear): raw samples at the last two edges, how
  // many samples exist since reset, the accepted level, the current run of
  // edges on which the two-edge-old sample disagreed with it, whether a real
  // released level has been seen, and whether a press is pending for the bank.
  bit              smp_prev1 [2];
  bit              smp_prev2 [2];
  int              nsamp     [2];
  bit              accepted  [2];
  int              run_len   [2];
  bit              armed     [2];
  bit              pend      [2];
  bit [DATA_W-1:0] m_ops [NUM_OPS];
  int              m_n;   // operands held; NUM_OPS means full

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        smp_prev1[b] = 1'b1;
        smp_prev2[b] = 1'b1;
        nsamp[b]     = 0;
        accepted[b]  = 1'b1;
        run_len[b]   = 0;
        armed[b]     = 1'b0;
        pend[b]      = 1'b0;
      end
      for (int i = 0; i < NUM_OPS; i++) m_ops[i] = '0;
      m_n = 0;
    end else begin
      bit raw [2];
      // bank reacts to presses reported before this edge
      if (pend[1]) begin
        for (int i = 0; i < NUM_OPS; i++) m_ops[i] = '0;
        m_n = 0;
      end else if (m_n == NUM_OPS) begin
        if (consume) m_n = 0;
      end else if (pend[0]) begin
        m_ops[m_n] = sw;
        m_n++;
      end
      raw[0] = load_btn;
      raw[1] = clr_btn;
      for (int b = 0; b < 2; b++) begin
        bit seen, old_acc, old_armed;
        seen      = (nsamp[b] >= 2) ? smp_prev2[b] : 1'b1;
        old_acc   = accepted[b];
        old_armed = armed[b];
        if (seen == accepted[b]) begin
          run_len[b] = 0;
        end else begin
          run_len[b]++;
          if (run_len[b] == DEB) begin
            accepted[b] = seen;
            run_len[b]  = 0;
          end
        end
        if (nsamp[b] >= 2 && seen && old_acc) armed[b] = 1'b1;
        pend[b] = old_armed && old_acc && !accepted[b];
        smp_prev2[b] = smp_prev1[b];
        smp_prev1[b] = raw[b];
        if (nsamp[b] < 2) nsamp[b]++;
      end
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (check_en) begin
      logic [NUM_OPS*DATA_W-1:0] e_flat;
      logic [NUM_OPS-1:0]        e_valid;
      int                        e_idx;
      for (int i = 0; i < NUM_OPS; i++) e_flat[i*DATA_W +: DATA_W] = m_ops[i];
      e_valid = NUM_OPS'((1 << m_n) - 1);
      e_idx   = (m_n == NUM_OPS) ? NUM_OPS - 1 : m_n;
      check("model_ops_flat",  32'(ops_flat),  32'(e_flat));
      check("model_op_valid",  32'(op_valid),  32'(e_valid));
      check("model_cur_idx",   32'(cur_idx),   32'(e_idx));
      check("model_all_valid", 32'(all_valid), 32'(m_n == NUM_OPS));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_load(input int hold);
    load_btn = 1'b0;
    tick(hold);
    load_btn = 1'b1;
    tick(12);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    int ld_left;
    int cl_left;
    rst      = 1'b1;
    load_btn = 1'b1;
    clr_btn  = 1'b1;
    consume  = 1'b0;
    sw       = '0;
    #1 rst   = 1'b0;
    check_en = 1'b1;

    // reset then idle
    tick(3);
    rst = 1'b1;
    check("rst_ops_flat",  32'(ops_flat),  32'h0000);
    check("rst_op_valid",  32'(op_valid),  32'h0);
    check("rst_cur_idx",   32'(cur_idx),   32'h0);
    check("rst_all_valid", 32'(all_valid), 32'h0);
    tick(10);
    check("idle_op_valid", 32'(op_valid), 32'h0);

    // sequential entry
    sw = 8'h2A;
    press_load(10);
    check("e1_op0",      32'(ops_flat[7:0]), 32'h2A);
    check("e1_op_valid", 32'(op_valid),      32'h1);
    check("e1_cur_idx",  32'(cur_idx),       32'h1);
    sw = 8'h05;
    press_load(10);
    check("e2_ops_flat",  32'(ops_flat),  32'h052A);
    check("e2_op_valid",  32'(op_valid),  32'h3);
    check("e2_all_valid", 32'(all_valid), 32'h1);

    // FULL ignores load; consume empties but keeps data
    sw = 8'hFF;
    press_load(10);
    check("full_ops_flat", 32'(ops_flat), 32'h052A);
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    tick(1);
    check("cons_op_valid",  32'(op_valid),  32'h0);
    check("cons_cur_idx",   32'(cur_idx),   32'h0);
    check("cons_all_valid", 32'(all_valid), 32'h0);
    check("cons_ops_flat",  32'(ops_flat),  32'h052A);

    // bouncing press: one capture, latency from the settled edge
    sw = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      load_btn = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    load_btn = 1'b0;
    waited = 0;
    while (op_valid == '0 && waited < 20) begin
      tick(1);
      waited++;
    end
    check("bounce_latency", 32'(waited), 32'(2 + DEB + 1));
    tick(8);
    load_btn = 1'b1;
    tick(12);
    check("bounce_op_valid", 32'(op_valid), 32'h1);
    check("bounce_cur_idx",  32'(cur_idx),  32'h1);
    check("bounce_ops_flat", 32'(ops_flat), 32'h053C);

    // short glitch is rejected
    sw = 8'h77;
    press_load(3);
    check("glitch_op_valid", 32'(op_valid), 32'h1);
    check("glitch_ops_flat", 32'(ops_flat), 32'h053C);

    // clear and load on the same cycle: clear wins
    sw = 8'h99;
    load_btn = 1'b0;
    clr_btn  = 1'b0;
    tick(10);
    load_btn = 1'b1;
    clr_btn  = 1'b1;
    tick(12);
    check("clr_ops_flat", 32'(ops_flat), 32'h0000);
    check("clr_op_valid", 32'(op_valid), 32'h0);
    check("clr_cur_idx",  32'(cur_idx),  32'h0);

    // async reset in FULL with load held through release
    sw = 8'h11;
    press_load(10);
    sw = 8'h22;
    press_load(10);
    check("pre_rst_all_valid", 32'(all_valid), 32'h1);
    check("pre_rst_ops_flat",  32'(ops_flat),  32'h2211);
    #2;
    rst      = 1'b0;
    load_btn = 1'b0;
    #1;
    check("async_ops_flat",  32'(ops_flat),  32'h0000);
    check("async_op_valid",  32'(op_valid),  32'h0);
    check("async_cur_idx",   32'(cur_idx),   32'h0);
    check("async_all_valid", 32'(all_valid), 32'h0);
    tick(3);
    rst = 1'b1;
    tick(15);
    check("held_op_valid", 32'(op_valid), 32'h0);
    load_btn = 1'b1;
    tick(12);
    check("release_op_valid", 32'(op_valid), 32'h0);
    sw = 8'h44;
    press_load(10);
    check("repress_op_valid", 32'(op_valid), 32'h1);
    check("repress_ops_flat", 32'(ops_flat), 32'h0044);

    // randomized phase
    ld_left = 0;
    cl_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (ld_left == 0) begin
        load_btn = ~load_btn;
        ld_left  = load_btn ? int'($urandom_range(2, 14)) : int'($urandom_range(1, 9));
      end
      if (cl_left == 0) begin
        clr_btn = ~clr_btn;
        cl_left = clr_btn ? int'($urandom_range(30, 120)) : int'($urandom_range(1, 8));
      end
      consume = ($urandom_range(0, 5) == 0);
      sw      = DATA_W'($urandom);
      ld_left--;
      cl_left--;
      tick(1);
    end
    load_btn = 1'b1;
    clr_btn  = 1'b1;
    consume  = 1'b0;
    tick(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
